write_deal: RTL and testbench

WRITE_DEAL -- requirements
Module: write_deal

---
 rtl/write_deal_pkg.sv | 46 ++++
 rtl/write_deal_gear_sync.sv | 26 ++
 rtl/write_deal.sv | 134 +++++++++++++
 tb/tb_write_deal.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/write_deal_pkg.sv
// Shared definitions for write_deal: FSM encoding, gear codes, frame-length table.
// WRITE_DEAL_HS_PATH_EN moves gears 42h/43h onto the 1280-byte high-speed path.
package write_deal_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_FILL  = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  localparam logic [7:0]  GEAR_NONE    = 8'h00;
  localparam logic [7:0]  GEAR_HS_LO   = 8'h42;
  localparam logic [7:0]  GEAR_HS_HI   = 8'h43;
  localparam logic [15:0] HS_FRAME_LEN = 16'd1280;
  localparam logic [2:0]  FLUSH_CYCLES = 3'd4;

  // Frame length in bytes for a gear code; 0 marks an unsupported gear.
  function automatic logic [15:0] frame_len(input logic [7:0] gear);
    logic [15:0] len;
    case (gear)
      8'h52:                         len = 16'd48;
      8'h51:                         len = 16'd20;
      8'h4F, 8'h4E:                  len = 16'd40;
      8'h4D, 8'h4C:                  len = 16'd80;
      8'h4B, 8'h4A:                  len = 16'd160;
      8'h49:                         len = 16'd320;
      8'h48, 8'h47, 8'h46, 8'h45,
      8'h44:                         len = 16'd160;
`ifdef WRITE_DEAL_HS_PATH_EN
      GEAR_HS_HI, GEAR_HS_LO:        len = HS_FRAME_LEN;
`else
      GEAR_HS_HI:                    len = 16'd320;
      GEAR_HS_LO:                    len = 16'd480;
`endif
      8'h41:                         len = 16'd480;
      default:                       len = 16'd0;
    endcase
    return len;
  endfunction

  function automatic logic is_hs_gear(input logic [7:0] gear);
    return (gear == GEAR_HS_LO) || (gear == GEAR_HS_HI);
  endfunction

endpackage

// File: rtl/write_deal_gear_sync.sv
// Two-flop synchroniser for the asynchronous downlink gear code, plus change detect.
module write_deal_gear_sync (
  input  logic       i_clk100m,
  input  logic       i_rst_n,
  input  logic [7:0] gear_i,
  output logic [7:0] gear_o,
  output logic       gear_chg_o
);

  logic [7:0] gear_r_q;
  logic [7:0] gear_rr_q;

  always_ff @(posedge i_clk100m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      gear_r_q  <= 8'h00;
      gear_rr_q <= 8'h00;
    end else begin
      gear_r_q  <= gear_i;
      gear_rr_q <= gear_r_q;
    end
  end

  assign gear_o     = gear_rr_q;
  assign gear_chg_o = (gear_rr_q != gear_r_q);

endmodule

// File: rtl/write_deal.sv
// Packs source bytes into gear-sized frames in a downstream FIFO and flushes it on gear change.
// WRITE_DEAL_HS_PATH_EN enables the high-speed flag path for gears 42h/43h.
module write_deal
  import write_deal_pkg::*;
(
  input  logic        i_clk100m,
  input  logic        i_rst_n,
  input  logic [7:0]  i_down_gear,
  input  logic [7:0]  i_data,
  input  logic        i_data_valid,
  input  logic        i_fifo_full,
  output logic        o_fifo_wr_en,
  output logic [7:0]  o_fifo_din,
  output logic        o_fifo_rst_n,
  output logic        o_ml_rd_flag,
  output logic        o_hs_rd_flag,
  output logic [15:0] o_drop_cnt
);

  state_e      state_q;
  logic [7:0]  gear;
  logic        gear_chg;
  logic [15:0] len_q;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [15:0] drop_cnt_q;
  logic [2:0]  flush_cnt_q;
  logic        wr_en_q;
  logic [7:0]  din_q;
  logic        fifo_rst_n_q;
  logic        ml_flag_q;
`ifdef WRITE_DEAL_HS_PATH_EN
  logic        hs_q;
  logic        hs_flag_q;
`endif

  write_deal_gear_sync u_gear_sync (
    .i_clk100m  (i_clk100m),
    .i_rst_n    (i_rst_n),
    .gear_i     (i_down_gear),
    .gear_o     (gear),
    .gear_chg_o (gear_chg)
  );

  assign cnt_d = cnt_q + 16'd1;

  always_ff @(posedge i_clk100m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      len_q        <= 16'd0;
      cnt_q        <= 16'd0;
      drop_cnt_q   <= 16'd0;
      flush_cnt_q  <= 3'd0;
      wr_en_q      <= 1'b0;
      din_q        <= 8'h00;
      fifo_rst_n_q <= 1'b1;
      ml_flag_q    <= 1'b0;
`ifdef WRITE_DEAL_HS_PATH_EN
      hs_q         <= 1'b0;
      hs_flag_q    <= 1'b0;
`endif
    end else begin
      // Strobes and flags are single-cycle unless re-asserted below.
      wr_en_q   <= 1'b0;
      ml_flag_q <= 1'b0;
`ifdef WRITE_DEAL_HS_PATH_EN
      hs_flag_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          cnt_q <= 16'd0;
          if (gear != GEAR_NONE && frame_len(gear) != 16'd0) state_q <= ST_SYNC;
        end
        ST_SYNC: begin
          if (gear_chg) begin
            state_q <= ST_IDLE;
          end else begin
            len_q   <= frame_len(gear);
`ifdef WRITE_DEAL_HS_PATH_EN
            hs_q    <= is_hs_gear(gear);
`endif
            state_q <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (gear_chg) begin
            // A gear change wins over any write or flag in the same cycle.
            state_q      <= ST_FLUSH;
            fifo_rst_n_q <= 1'b0;
            flush_cnt_q  <= 3'd0;
          end else if (i_data_valid && !i_fifo_full) begin
            din_q   <= i_data;
            wr_en_q <= 1'b1;
            if (cnt_d == len_q) begin
              cnt_q <= 16'd0;
`ifdef WRITE_DEAL_HS_PATH_EN
              if (hs_q) hs_flag_q <= 1'b1;
              else      ml_flag_q <= 1'b1;
`else
              ml_flag_q <= 1'b1;
`endif
            end else begin
              cnt_q <= cnt_d;
            end
          end else if (i_data_valid) begin
            if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
          end
        end
        ST_FLUSH: begin
          cnt_q       <= 16'd0;
          drop_cnt_q  <= 16'd0;
          flush_cnt_q <= flush_cnt_q + 3'd1;
          if (flush_cnt_q == FLUSH_CYCLES - 3'd1) begin
            fifo_rst_n_q <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_fifo_wr_en = wr_en_q;
  assign o_fifo_din   = din_q;
  assign o_fifo_rst_n = fifo_rst_n_q;
  assign o_ml_rd_flag = ml_flag_q;
  assign o_drop_cnt   = drop_cnt_q;
`ifdef WRITE_DEAL_HS_PATH_EN
  assign o_hs_rd_flag = hs_flag_q;
`else
  assign o_hs_rd_flag = 1'b0;
`endif

endmodule

// File: tb/tb_write_deal.sv
// Self-checking bench for write_deal: scoreboard of expected {hs_flag, ml_flag, data} per FIFO write.
module tb_write_deal;

  logic        i_clk100m = 1'b0;
  logic        i_rst_n;
  logic [7:0]  i_down_gear;
  logic [7:0]  i_data;
  logic        i_data_valid;
  logic        i_fifo_full;
  logic        o_fifo_wr_en;
  logic [7:0]  o_fifo_din;
  logic        o_fifo_rst_n;
  logic        o_ml_rd_flag;
  logic        o_hs_rd_flag;
  logic [15:0] o_drop_cnt;

  write_deal dut (
    .i_clk100m    (i_clk100m),
    .i_rst_n      (i_rst_n),
    .i_down_gear  (i_down_gear),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .i_fifo_full  (i_fifo_full),
    .o_fifo_wr_en (o_fifo_wr_en),
    .o_fifo_din   (o_fifo_din),
    .o_fifo_rst_n (o_fifo_rst_n),
    .o_ml_rd_flag (o_ml_rd_flag),
    .o_hs_rd_flag (o_hs_rd_flag),
    .o_drop_cnt   (o_drop_cnt)
  );

  // clock
  always #5 i_clk100m = ~i_clk100m;

  // scoreboard state and reference model
  logic [9:0] exp_q[$];
  logic [9:0] exp_item;
  int n_chk = 0;
  int n_err = 0;
  int model_len = 0;
  bit model_hs = 1'b0;
  int model_cnt = 0;
  int exp_drop = 0;
  int exp_ml = 0;
  int exp_hs = 0;
  int ml_seen = 0;
  int hs_seen = 0;
  int wr_seen = 0;
  int rst_low = 0;
  logic [7:0] cur_gear = 8'h00;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int ref_len(input logic [7:0] g);
`ifdef WRITE_DEAL_HS_PATH_EN
    if (g == 8'h42 || g == 8'h43) return 1280;
`endif
    if (g == 8'h52) return 48;
    if (g == 8'h51) return 20;
    if (g == 8'h4F || g == 8'h4E) return 40;
    if (g == 8'h4D || g == 8'h4C) return 80;
    if (g == 8'h4B || g == 8'h4A) return 160;
    if (g == 8'h49) return 320;
    if (g >= 8'h44 && g <= 8'h48) return 160;
    if (g == 8'h43) return 320;
    if (g == 8'h42 || g == 8'h41) return 480;
    return 0;
  endfunction

  function automatic bit ref_hs(input logic [7:0] g);
`ifdef WRITE_DEAL_HS_PATH_EN
    return (g == 8'h42 || g == 8'h43);
`else
    return (g == 8'hFF) && (g == 8'h00);
`endif
  endfunction

  // monitor: every write is matched against the head of the expected queue
  always @(negedge i_clk100m) begin
    if (i_rst_n === 1'b1) begin
      if (!o_fifo_rst_n) rst_low++;
      if (o_ml_rd_flag) ml_seen++;
      if (o_hs_rd_flag) hs_seen++;
      if (o_fifo_wr_en) begin
        wr_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(o_fifo_din), 32'hFFFF_FFFF);
        end else begin
          exp_item = exp_q.pop_front();
          check("write_hs_ml_data", 32'({o_hs_rd_flag, o_ml_rd_flag, o_fifo_din}), 32'(exp_item));
        end
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk100m);
      i_data_valid = 1'b0;
      i_fifo_full  = 1'b0;
    end
  endtask

  task automatic set_gear(input logic [7:0] g);
    @(negedge i_clk100m);
    i_data_valid = 1'b0;
    i_fifo_full  = 1'b0;
    if (model_len != 0 && g != cur_gear) exp_drop = 0;
    cur_gear    = g;
    model_len   = ref_len(g);
    model_hs    = ref_hs(g);
    model_cnt   = 0;
    rst_low     = 0;
    i_down_gear = g;
    idle(14);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit full);
    bit flag;
    @(negedge i_clk100m);
    i_data       = d;
    i_data_valid = 1'b1;
    i_fifo_full  = full;
    if (model_len != 0) begin
      if (full) begin
        if (exp_drop < 65535) exp_drop++;
      end else begin
        model_cnt++;
        flag = (model_cnt == model_len);
        if (flag) begin
          model_cnt = 0;
          if (model_hs) exp_hs++;
          else          exp_ml++;
        end
        exp_q.push_back({flag & model_hs, flag & ~model_hs, d});
      end
    end
  endtask

  task automatic send_random(input int n);
    for (int i = 0; i < n; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_ml_flags"}, 32'(ml_seen), 32'(exp_ml));
    check({tag, "_hs_flags"}, 32'(hs_seen), 32'(exp_hs));
    check({tag, "_drop_cnt"}, 32'(o_drop_cnt), 32'(exp_drop));
    check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int wr_before;
    i_rst_n      = 1'b0;
    i_down_gear  = 8'h00;
    i_data       = 8'h00;
    i_data_valid = 1'b0;
    i_fifo_full  = 1'b0;
    #23;
    check("rst_wr_en", 32'(o_fifo_wr_en), 32'd0);
    check("rst_din", 32'(o_fifo_din), 32'd0);
    check("rst_fifo_rst_n", 32'(o_fifo_rst_n), 32'd1);
    check("rst_ml_flag", 32'(o_ml_rd_flag), 32'd0);
    check("rst_hs_flag", 32'(o_hs_rd_flag), 32'd0);
    check("rst_drop_cnt", 32'(o_drop_cnt), 32'd0);
    @(negedge i_clk100m);
    i_rst_n = 1'b1;
    idle(2);

    // gear 51h: 20 bytes 00h..13h, flag on the last, then a second frame from count 0
    set_gear(8'h51);
    for (int i = 0; i < 20; i++) send_byte(8'(i), 1'b0);
    idle(3);
    check("g51_writes", 32'(wr_seen), 32'd20);
    check_counts("g51");
    send_random(20);
    idle(3);
    check_counts("g51_second");

    // gear 52h: 60 bytes, one flag at 48, 12 pending
    set_gear(8'h52);
    check("g52_flush_len", 32'(rst_low), 32'd4);
    send_random(60);
    idle(3);
    check_counts("g52");

    // gear 4Eh: bytes 5..7 of 40 dropped, frame completes after 3 more
    set_gear(8'h4E);
    for (int i = 0; i < 40; i++) send_byte(8'($urandom_range(0, 255)), (i >= 4 && i <= 6));
    idle(3);
    check("g4e_drop3", 32'(o_drop_cnt), 32'd3);
    check_counts("g4e_partial");
    send_random(3);
    idle(3);
    check_counts("g4e_done");

    // gear 51h partial frame with a drop, then change to 4Ch
    set_gear(8'h51);
    check("g51b_flush_len", 32'(rst_low), 32'd4);
    check_counts("g51b_entry");
    send_random(10);
    send_byte(8'h77, 1'b1);
    idle(3);
    check("g51b_drop1", 32'(o_drop_cnt), 32'd1);
    set_gear(8'h4C);
    check("g4c_flush_len", 32'(rst_low), 32'd4);
    check_counts("g4c_after_flush");
    send_random(80);
    idle(3);
    check_counts("g4c_frame");

    // gear 43h: high-speed path with the macro, medium/low path without
    set_gear(8'h43);
    send_random(ref_len(8'h43));
    idle(3);
    check_counts("g43");

    // unsupported gears: no writes
    set_gear(8'h00);
    wr_before = wr_seen;
    send_random(10);
    idle(3);
    check("g00_no_writes", 32'(wr_seen), 32'(wr_before));
    set_gear(8'h50);
    send_random(10);
    idle(3);
    check("g50_no_writes", 32'(wr_seen), 32'(wr_before));

    // asynchronous reset in the middle of a frame
    set_gear(8'h51);
    send_random(3);
    send_byte(8'h3C, 1'b1);
    send_byte(8'hA5, 1'b0);
    @(negedge i_clk100m);
    i_data_valid = 1'b0;
    check("pre_rst_wr_en", 32'(o_fifo_wr_en), 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_wr_en", 32'(o_fifo_wr_en), 32'd0);
    check("arst_din", 32'(o_fifo_din), 32'd0);
    check("arst_fifo_rst_n", 32'(o_fifo_rst_n), 32'd1);
    check("arst_ml_flag", 32'(o_ml_rd_flag), 32'd0);
    check("arst_hs_flag", 32'(o_hs_rd_flag), 32'd0);
    check("arst_drop_cnt", 32'(o_drop_cnt), 32'd0);
    idle(3);
    i_rst_n   = 1'b1;
    exp_drop  = 0;
    model_cnt = 0;
    idle(10);
    send_random(20);
    idle(3);
    check_counts("after_reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
